csr_irq_ctrl: RTL and testbench
===============================

Name: csr_irq_ctrl

Overview:
- Parametrised machine-mode CSR and trap controller; successor to the single-line interrupt CSR unit.
- Adds NUM_IRQ platform interrupt lines with sticky pending latches and fixed priority.
- Adds vectored mtvec mode, MIE/MPIE save/restore, and 64-bit mcycle/minstret counters.
- Sits beside decode/execute: consumes csr_op from decode and rs1 data; drives the PC redirect (int_flag/int_addr) to fetch.

Parameters:
- NUM_IRQ, 4, platform interrupt lines (1..16); line k maps to mip/mie bit 16+k.
- RESET_VEC, 32'h0000_0000, mtvec reset value.
- CNT_EN, 1, 1 = mcycle/minstret implemented; 0 = they read 0 and writes are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- pc  in  32  PC of the instruction in execute.
- qa  in  32  rs1 data.
- retire  in  1  instruction retired this cycle, active-high.
- irq  in  NUM_IRQ  platform interrupts, ACTIVE LOW, already synchronous.
- ti  in  1  timer interrupt, ACTIVE LOW, level.
- csr_op  in  7  {ecall, ebreak, mret, csrrw, csrrs, csrrc, is_imm}, ACTIVE LOW.
- csr_zimm  in  5  immediate operand.
- csr_addr  in  12  CSR address.
- csr_rdata  out  32  read data, combinational.
- int_flag  out  1  redirect request, ACTIVE LOW, registered.
- int_addr  out  32  redirect target, registered.

Behaviour:
- Operand and CSR writes:
  - Write operand = is_imm low ? zero-extended zimm : qa.
  - rw writes the operand; rs writes old|op; rc writes old&~op.
- Register map:
  - mstatus 0x300: MIE b3, MPIE b7, MPP[12:11] hardwired 11, other bits 0.
  - mie 0x304: bits 3, 7, 11, 16+k writable.
  - mtvec 0x305: BASE[31:2], MODE[1:0] (0 direct, 1 vectored; values 2/3 are written as 0).
  - mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mtval 0x343.
  - mip 0x344: read-only.
  - mipclr 0x7C0: write-1-to-clear platform pending bits; reads 0.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
- Unmapped address: reads 0, writes ignored. csr_rdata = 0 when no csr op is active.
- mip composition:
  - b7 = ~ti, sampled every cycle.
  - b16+k = sticky pend[k]; set when irq[k] is low, cleared only by an mipclr write.
  - Set wins over a same-cycle clear.
  - b11 = OR of (pend & mie[16+:NUM_IRQ]).
- Trap priority, highest first:
  - ecall: mcause 11.
  - ebreak: mcause 3, mtval = pc.
  - Platform irq lowest k: mcause 0x8000_0000 | (16+k).
  - Timer: mcause 0x8000_0007.
- Take conditions:
  - Exceptions are always taken.
  - Interrupts are taken only when mstatus.MIE=1 and the mie bit matching the pending mip bit is set.
  - Non-ebreak traps write mtval = 0.
- Trap cycle (registered update):
  - mepc ← {pc[31:2], 2'b0}; mcause as above; MPIE ← MIE; MIE ← 0.
  - int_flag low next cycle.
  - int_addr = BASE; in vectored mode, interrupts use BASE + 4·(mcause[4:0]).
- mret: MIE ← MPIE, MPIE ← 1, int_flag low next cycle, int_addr = mepc. mret has lower priority than ecall/ebreak and higher than interrupts.
- FSM:
  - RUN: trap or mret → REDIR.
  - REDIR (1 cycle, int_flag low): all csr_op inputs ignored (flushed slot); → RUN.
  - Interrupts pending at REDIR are evaluated in the first RUN cycle.
- Simultaneous events: a trap in the same cycle as a CSR write to mepc/mcause/mstatus → trap update wins; writes to other CSRs complete.
- Counters:
  - 64-bit; mcycle +1 every cycle, minstret +1 when retire=1, with carry into the high word.
  - A software write to either half that cycle replaces that half and suppresses the increment for the whole counter.
  - Wrap 2^64−1 → 0.
- Reset:
  - All CSRs 0, except mstatus reads 0x0000_1800 and mtvec = RESET_VEC.
  - pend = 0, counters = 0, FSM = RUN, int_flag = 1, int_addr = 0.
  - Reset overrides any in-flight trap or REDIR.

Decomposition:
- Package csr_pkg: CSR address constants, cause codes, mstatus bit indices, mtvec mode enum, FSM state typedef.
- Sub-module csr_counter64: load-lo/load-hi/inc inputs, with write priority over inc; instantiated twice.

Test Plan:
- Reset, then read 0x300 → 0x1800; read 0x305 → RESET_VEC; int_flag=1.
- mtvec=0x100|1, mie=0x10000|0x8, MIE=1, drive irq[0] low at pc=0x40 → int_flag low 1 cycle, int_addr=0x140, mcause=0x80000010, mepc=0x40, MIE=0, MPIE=1.
- pc=0x22 ecall with irq[1] and ti pending, MIE=1 → mcause=11, mepc=0x20, int_addr=0x100 (exceptions not vectored); mret → int_addr=0x20, MIE=1.
- irq[2] pulsed low 1 cycle with mie bit clear → mip bit 18 stays 1; write 0x40000 to 0x7C0 → bit 18 clears; same cycle with irq[2] low → bit stays set.
- Preload mcycle=0xFFFFFFFF, mcycleh=0 → two cycles later {mcycleh,mcycle}=0x1_00000001; csrrw to mcycle while counting → written value read next cycle, no increment applied.
- Trap with csrrw mepc=0x500 in the same cycle → mepc = trapping pc; ecall in REDIR cycle → ignored, no second int_flag.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR and trap controller: CSR addresses,
// cause codes, mstatus bit positions, mtvec modes and controller states.
package csr_pkg;

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMipclr   = 12'h7C0;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;
  localparam logic [11:0] AddrMcycleh  = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;

  localparam logic [31:0] CauseEcall  = 32'd11;
  localparam logic [31:0] CauseEbreak = 32'd3;
  localparam logic [4:0]  CodeTimer   = 5'd7;
  localparam logic [4:0]  CodeIrqBase = 5'd16;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned CntW        = 64;

  typedef enum logic [1:0] {
    MtvecDirect   = 2'd0,
    MtvecVectored = 2'd1
  } mtvec_mode_e;

  typedef logic [0:0] state_t;
  localparam state_t StRun   = 1'b0;
  localparam state_t StRedir = 1'b1;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter; a software write to either half takes priority
// over the increment and suppresses it for the whole counter.
module csr_counter64 import csr_pkg::*; #(
  parameter bit Enable = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     wdata,
  input  logic            load_lo,
  input  logic            load_hi,
  input  logic            inc,
  output logic [CntW-1:0] value
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_lo || load_hi) begin
      if (load_lo) cnt_d[31:0] = wdata;
      if (load_hi) cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !Enable) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and trap controller: sticky platform interrupts, fixed
// priority trap selection, vectored mtvec and a one-cycle PC redirect to fetch.
module csr_irq_ctrl import csr_pkg::*; #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter bit          CNT_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic [31:0]        qa,
  input  logic               retire,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ti,
  input  logic [6:0]         csr_op,
  input  logic [4:0]         csr_zimm,
  input  logic [11:0]        csr_addr,
  output logic [31:0]        csr_rdata,
  output logic               int_flag,
  output logic [31:0]        int_addr
);

  localparam logic [31:0] MieMask =
      32'h0000_0888 | (32'((64'd1 << NUM_IRQ) - 64'd1) << 16);

  state_t             st_q, st_d;
  logic               status_mie_q, status_mie_d, status_mpie_q, status_mpie_d;
  logic [31:0]        mie_q, mie_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d, mtval_q, mtval_d;
  logic [29:0]        base_q, base_d;
  mtvec_mode_e        mode_q, mode_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, irq_en;
  logic               mtip_q, int_flag_q, int_flag_d;
  logic [31:0]        int_addr_q, int_addr_d;
  logic [63:0]        mcycle, minstret;

  // Decode is blanked in the redirect cycle: that slot holds a flushed instruction.
  logic run, op_ecall, op_ebreak, op_mret, op_rw, op_rs, op_rc, csr_act;
  assign run       = (st_q == StRun);
  assign op_ecall  = run & ~csr_op[6];
  assign op_ebreak = run & ~csr_op[5];
  assign op_mret   = run & ~csr_op[4];
  assign op_rw     = run & ~csr_op[3];
  assign op_rs     = run & ~csr_op[2];
  assign op_rc     = run & ~csr_op[1];
  assign csr_act   = op_rw | op_rs | op_rc;

  logic [31:0] operand, rd_val, wdata, mip;
  assign operand = csr_op[0] ? qa : {27'b0, csr_zimm};
  assign irq_en  = pend_q & mie_q[16 +: NUM_IRQ];

  always_comb begin
    mip = '0;
    mip[16 +: NUM_IRQ] = pend_q;
    mip[7]  = mtip_q;
    mip[11] = |irq_en;
  end

  always_comb begin
    rd_val = '0;
    case (csr_addr)
      AddrMstatus:   rd_val = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
      AddrMie:       rd_val = mie_q;
      AddrMtvec:     rd_val = {base_q, mode_q};
      AddrMscratch:  rd_val = mscratch_q;
      AddrMepc:      rd_val = mepc_q;
      AddrMcause:    rd_val = mcause_q;
      AddrMtval:     rd_val = mtval_q;
      AddrMip:       rd_val = mip;
      AddrMcycle:    rd_val = mcycle[31:0];
      AddrMcycleh:   rd_val = mcycle[63:32];
      AddrMinstret:  rd_val = minstret[31:0];
      AddrMinstreth: rd_val = minstret[63:32];
      default:       rd_val = '0;
    endcase
  end

  assign csr_rdata = csr_act ? rd_val : '0;

  always_comb begin
    if (op_rw)      wdata = operand;
    else if (op_rs) wdata = rd_val | operand;
    else            wdata = rd_val & ~operand;
  end

  // Lowest-numbered enabled platform line wins; timer only when none is pending.
  logic       irq_hit, tim_hit, int_take, exc, trap, mret_take;
  logic [4:0] irq_code, int_code;
  always_comb begin
    irq_hit  = 1'b0;
    irq_code = CodeIrqBase;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      if (irq_en[k] && !irq_hit) begin
        irq_hit  = 1'b1;
        irq_code = 5'(16 + k);
      end
    end
  end

  assign tim_hit   = mtip_q & mie_q[7];
  assign exc       = op_ecall | op_ebreak;
  assign int_take  = run & status_mie_q & (irq_hit | tim_hit) & ~exc & ~op_mret;
  assign trap      = exc | int_take;
  assign mret_take = op_mret & ~exc;
  assign int_code  = irq_hit ? irq_code : CodeTimer;

  logic [31:0] trap_cause, trap_vec;
  assign trap_cause = op_ecall  ? CauseEcall :
                      op_ebreak ? CauseEbreak : {1'b1, 26'b0, int_code};
  assign trap_vec   = (int_take && mode_q == MtvecVectored) ?
                      {base_q, 2'b0} + {25'b0, int_code, 2'b0} : {base_q, 2'b0};

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    base_d        = base_q;
    mode_d        = mode_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    pend_d        = pend_q;
    st_d          = StRun;
    int_flag_d    = 1'b1;
    int_addr_d    = int_addr_q;
    if (csr_act) begin
      case (csr_addr)
        AddrMstatus: begin
          status_mie_d  = wdata[MstatusMie];
          status_mpie_d = wdata[MstatusMpie];
        end
        AddrMie:      mie_d = wdata & MieMask;
        AddrMtvec: begin
          base_d = wdata[31:2];
          mode_d = (wdata[1:0] == 2'd1) ? MtvecVectored : MtvecDirect;
        end
        AddrMscratch: mscratch_d = wdata;
        AddrMepc:     mepc_d = {wdata[31:2], 2'b0};
        AddrMcause:   mcause_d = wdata;
        AddrMtval:    mtval_d = wdata;
        AddrMipclr:   pend_d = pend_q & ~wdata[16 +: NUM_IRQ];
        default: ;
      endcase
    end
    pend_d = pend_d | ~irq;
    // Trap and mret updates override any same-cycle software write to these CSRs.
    if (trap) begin
      mepc_d        = {pc[31:2], 2'b0};
      mcause_d      = trap_cause;
      mtval_d       = (op_ebreak && !op_ecall) ? pc : 32'h0;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
      st_d          = StRedir;
      int_flag_d    = 1'b0;
      int_addr_d    = trap_vec;
    end else if (mret_take) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
      st_d          = StRedir;
      int_flag_d    = 1'b0;
      int_addr_d    = mepc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= StRun;
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      base_q        <= RESET_VEC[31:2];
      mode_q        <= (RESET_VEC[1:0] == 2'd1) ? MtvecVectored : MtvecDirect;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      pend_q        <= '0;
      mtip_q        <= 1'b0;
      int_flag_q    <= 1'b1;
      int_addr_q    <= '0;
    end else begin
      st_q          <= st_d;
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      base_q        <= base_d;
      mode_q        <= mode_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      pend_q        <= pend_d;
      mtip_q        <= ~ti;
      int_flag_q    <= int_flag_d;
      int_addr_q    <= int_addr_d;
    end
  end

  assign int_flag = int_flag_q;
  assign int_addr = int_addr_q;

  csr_counter64 #(.Enable(CNT_EN)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .wdata   (wdata),
    .load_lo (csr_act && csr_addr == AddrMcycle),
    .load_hi (csr_act && csr_addr == AddrMcycleh),
    .inc     (1'b1),
    .value   (mcycle)
  );

  csr_counter64 #(.Enable(CNT_EN)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .wdata   (wdata),
    .load_lo (csr_act && csr_addr == AddrMinstret),
    .load_hi (csr_act && csr_addr == AddrMinstreth),
    .inc     (retire),
    .value   (minstret)
  );

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Scoreboard bench for csr_irq_ctrl: each driven cycle queues the values expected
// on csr_rdata / int_flag / int_addr, and a negedge monitor retires them.
module tb_csr_irq_ctrl;

  localparam int unsigned NIrq = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     pc, qa;
  logic            retire, ti;
  logic [NIrq-1:0] irq;
  logic [6:0]      csr_op;
  logic [4:0]      csr_zimm;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_rdata, int_addr;
  logic            int_flag;

  localparam logic [6:0] OpNone    = 7'h7F;
  localparam logic [6:0] OpEcall   = 7'h3F;
  localparam logic [6:0] OpEbreak  = 7'h5F;
  localparam logic [6:0] OpMret    = 7'h6F;
  localparam logic [6:0] OpRw      = 7'h77;
  localparam logic [6:0] OpRs      = 7'h7B;
  localparam logic [6:0] OpRc      = 7'h7D;
  localparam logic [6:0] OpRwImm   = 7'h76;
  localparam logic [6:0] OpEcallRw = 7'h37;

  localparam int SelRdata = 0;
  localparam int SelFlag  = 1;
  localparam int SelAddr  = 2;

  csr_irq_ctrl #(
    .NUM_IRQ   (NIrq),
    .RESET_VEC (32'h0000_0200),
    .CNT_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .qa        (qa),
    .retire    (retire),
    .irq       (irq),
    .ti        (ti),
    .csr_op    (csr_op),
    .csr_zimm  (csr_zimm),
    .csr_addr  (csr_addr),
    .csr_rdata (csr_rdata),
    .int_flag  (int_flag),
    .int_addr  (int_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    int unsigned due;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].due == cyc) begin
        case (sbq[i].sel)
          SelRdata: check_val(sbq[i].tag, csr_rdata, sbq[i].exp);
          SelFlag:  check_val(sbq[i].tag, {31'b0, int_flag}, sbq[i].exp);
          default:  check_val(sbq[i].tag, int_addr, sbq[i].exp);
        endcase
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input string tag, input int sel, input int unsigned off,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.due = cyc + off;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [6:0] op, input logic [11:0] addr, input logic [31:0] data,
                       input logic [4:0] zimm = 5'd0);
    @(posedge clk);
    #1;
    csr_op   = op;
    csr_addr = addr;
    qa       = data;
    csr_zimm = zimm;
  endtask

  task automatic idle();
    drive(OpNone, 12'h000, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    drive(OpRs, addr, 32'h0);
    push(tag, SelRdata, 0, exp);
  endtask

  task automatic expect_redirect(input string tag, input logic [31:0] target);
    push({tag, "_flag"}, SelFlag, 1, 32'h0);
    push({tag, "_addr"}, SelAddr, 1, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    pc = 32'h40; qa = '0; retire = 1'b0; irq = '1; ti = 1'b1;
    csr_op = OpNone; csr_zimm = '0; csr_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state, observed in the first cycle after reset is released
    drive(OpRs, 12'h300, 32'h0);
    rst = 1'b0;
    push("rst_mstatus", SelRdata, 0, 32'h0000_1800);
    push("rst_flag", SelFlag, 0, 32'h1);
    push("rst_addr", SelAddr, 0, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0000_0200);

    // Vectored platform interrupt
    drive(OpRw, 12'h305, 32'h101);
    drive(OpRw, 12'h304, 32'h10008);
    drive(OpRs, 12'h300, 32'h8);
    rd("mie_rb", 12'h304, 32'h10008);
    idle(); irq[0] = 1'b0;
    push("irq0_noflag", SelFlag, 1, 32'h1);
    push("irq0_flag", SelFlag, 2, 32'h0);
    push("irq0_addr", SelAddr, 2, 32'h140);
    push("irq0_flag_end", SelFlag, 3, 32'h1);
    idle(); irq[0] = 1'b1;
    idle();
    rd("irq0_mcause", 12'h342, 32'h8000_0010);
    rd("irq0_mepc", 12'h341, 32'h40);
    rd("irq0_mstatus", 12'h300, 32'h0000_1880);
    drive(OpRw, 12'h7C0, 32'h10000);
    rd("mip_clear0", 12'h344, 32'h0);

    // ecall beats pending enabled interrupts; then mret; then the interrupt lands
    drive(OpRw, 12'h304, 32'h20080);
    idle(); irq[1] = 1'b0; ti = 1'b0;
    rd("mip_pend", 12'h344, 32'h0002_0880);
    drive(OpRs, 12'h300, 32'h8);
    drive(OpEcall, 12'h000, 32'h0); pc = 32'h22;
    expect_redirect("ecall", 32'h100);
    idle(); pc = 32'h40;
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mepc", 12'h341, 32'h20);
    drive(OpMret, 12'h000, 32'h0);
    expect_redirect("mret", 32'h20);
    idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    expect_redirect("irq1", 32'h144);
    idle(); irq[1] = 1'b1; ti = 1'b1;
    rd("irq1_mcause", 12'h342, 32'h8000_0011);
    drive(OpRw, 12'h7C0, 32'h20000);

    // Sticky pending bit and mipclr
    idle(); irq[2] = 1'b0;
    rd("mip18_set", 12'h344, 32'h40000); irq[2] = 1'b1;
    rd("mip18_hold", 12'h344, 32'h40000);
    drive(OpRw, 12'h7C0, 32'h40000);
    rd("mip18_clr", 12'h344, 32'h0);
    drive(OpRw, 12'h7C0, 32'h40000); irq[2] = 1'b0;
    rd("mip18_setwins", 12'h344, 32'h40000); irq[2] = 1'b1;
    rd("mipclr_rd", 12'h7C0, 32'h0);
    drive(OpRw, 12'h7C0, 32'h40000);

    // Counters: carry into the high word, write suppresses increment
    drive(OpRw, 12'hB00, 32'hFFFF_FFFF);
    drive(OpRw, 12'hB80, 32'h0);
    idle();
    idle();
    rd("mcycle_lo", 12'hB00, 32'h1);
    rd("mcycle_hi", 12'hB80, 32'h1);
    drive(OpRw, 12'hB00, 32'h1234);
    rd("mcycle_wr", 12'hB00, 32'h1234);
    drive(OpRw, 12'hB02, 32'h0);
    drive(OpRw, 12'hB82, 32'h0);
    for (int n = 0; n < 3; n++) begin
      idle(); retire = 1'b1;
    end
    rd("minstret_lo", 12'hB02, 32'h3); retire = 1'b0;
    rd("minstret_hi", 12'hB82, 32'h0);

    // Trap beats a same-cycle mepc write; ecall in the redirect slot is dropped
    drive(OpEcallRw, 12'h341, 32'h500); pc = 32'h80;
    expect_redirect("ecall_wr", 32'h100);
    drive(OpEcall, 12'h000, 32'h0); pc = 32'h90;
    push("redir_ecall_ignored", SelFlag, 1, 32'h1);
    push("redir_ecall_ignored2", SelFlag, 2, 32'h1);
    rd("ecall_wr_mepc", 12'h341, 32'h80);
    rd("ecall_wr_mcause", 12'h342, 32'd11);

    // ebreak records pc in mtval
    drive(OpEbreak, 12'h000, 32'h0); pc = 32'h64;
    expect_redirect("ebreak", 32'h100);
    idle(); pc = 32'h40;
    rd("ebreak_mcause", 12'h342, 32'd3);
    rd("ebreak_mtval", 12'h343, 32'h64);

    // Operand forms, masking and decode corner cases
    drive(OpRwImm, 12'h340, 32'hFFFF_FFFF, 5'h15);
    rd("mscratch_imm", 12'h340, 32'h15);
    drive(OpRc, 12'h340, 32'h5);
    rd("mscratch_rc", 12'h340, 32'h10);
    drive(OpRw, 12'h341, 32'h123);
    rd("mepc_align", 12'h341, 32'h120);
    drive(OpRw, 12'h305, 32'h203);
    rd("mtvec_mode3", 12'h305, 32'h200);
    rd("unmapped", 12'h123, 32'h0);
    drive(OpNone, 12'h300, 32'h0);
    push("noop_rdata", SelRdata, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drain", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
